// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic chain of DEPTH pipeline registers, each WIDTH bits wide
// and each with its own valid bit. It supports valid/ready backpressure, a global
// stall, a per-stage flush and bubble collapsing.
//
// Ports:
//   clk, rst_n             rising-edge clock, async active-low reset
//   in_valid/in_data       upstream payload; in_ready = stage 0 can accept this cycle
//   out_valid/out_data     stage DEPTH-1 payload; out_ready = consumer accepts
//   stall                  freeze the whole chain (flush still applies)
//   flush_mask[k]          stage k is invalid after this edge
//   occupancy              count of valid stages (registered)
//   perf_stall/perf_bubble saturating performance counters
//
// Optional feature: define PIPE_PERF_CNT_EN to build the performance counters.
// When it is undefined, both counters are tied to zero and no counter flops exist.
module pipe_stage_chain #(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    input  logic                         stall,
    input  logic [DEPTH-1:0]             flush_mask,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [31:0]                  perf_stall,
    output logic [31:0]                  perf_bubble
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_nxt;
    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [DEPTH-1:0] src_valid;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] load;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_nxt;
    logic             rdy_out;

    // Each stage's source: stage 0 takes the upstream port, others the previous stage.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int k = 1; k < int'(DEPTH); k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
        end
    end

    // Stage k is ready when any stage at or beyond k is empty, or the consumer drains.
    // The hole accumulator is the unrolled form of rdy[k] = ~valid[k] | rdy[k+1].
    always_comb begin
        logic hole;
        rdy_out = out_ready & ~stall;
        rdy     = '0;
        load    = '0;
        hole    = rdy_out;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            hole    = hole | ~valid_q[k];
            rdy[k]  = hole;
            load[k] = hole & ~stall;
        end
    end

    // Next valid bits: a load copies the source valid, and a flush overrides both load and hold.
    always_comb begin
        valid_nxt = valid_q;
        occ_nxt   = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (load[k]) begin
                valid_nxt[k] = src_valid[k];
            end
            if (flush_mask[k]) begin
                valid_nxt[k] = 1'b0;
            end
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_nxt = occ_nxt + OCC_W'(valid_nxt[k]);
        end
    end

    // Stage registers. Data only moves with a valid payload, so stale contents stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= RESET_DATA;
            end
        end else begin
            valid_q <= valid_nxt;
            occ_q   <= occ_nxt;
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (load[k] && src_valid[k]) begin
                    data_q[k] <= src_data[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0] & ~stall;
    assign out_valid = valid_q[DEPTH-1] & ~stall;
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic        bubble_cyc;

    // A bubble is a cycle where the consumer could take data but none is presented.
    assign bubble_cyc = out_ready & ~out_valid & ~stall;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bubble_cyc && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall  = stall_cnt_q;
    assign perf_bubble = bubble_cnt_q;
`else
    assign perf_stall  = 32'h0;
    assign perf_bubble = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain (DEPTH=4, WIDTH=32). The driver pushes expected
// payloads into a queue as they are accepted. A monitor pops from the queue and
// compares against out_data on every output transfer. Directed checks cover the
// handshake, occupancy, stall, flush and reset behaviour.
module tb_pipe_stage_chain;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_D = 32'hDEAD_0000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        stall;
    logic [3:0]  flush_mask;
    logic [2:0]  occupancy;
    logic [31:0] perf_stall;
    logic [31:0] perf_bubble;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pipe_stage_chain #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_DATA (RST_D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stall       (stall),
        .flush_mask  (flush_mask),
        .occupancy   (occupancy),
        .perf_stall  (perf_stall),
        .perf_bubble (perf_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, then sample at the falling edge.
    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic stl, input logic [3:0] fm);
        @(posedge clk);
        #1;
        in_valid   = iv;
        in_data    = d;
        out_ready  = ordy;
        stall      = stl;
        flush_mask = fm;
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(d);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000);
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Remove a payload that the chain is expected to discard.
    task automatic drop_exp(input logic [31:0] v);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i] == v) begin
                exp_q.delete(i);
                break;
            end
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected none", out_data);
            end else begin
                chk("sb_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int occ_e;
        int t3_iv[6]  = '{1, 0, 1, 1, 1, 1};
        int t3_rdy[6] = '{1, 1, 1, 1, 1, 0};
        int t3_occ[6] = '{0, 1, 1, 2, 3, 4};
        logic [31:0] perf_stall_e;
        logic [31:0] perf_bubble_e;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall = 1'b0; flush_mask = '0;
        #11;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, RST_D);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
        chk("rst_perf_bubble", perf_bubble, 32'd0);
        rst_n = 1'b1;

        // 1: back-to-back stream with four cycles of fill latency.
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0, 4'b0000);
            else       drive(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000);
            occ_e = (i < 4) ? i : ((i <= 8) ? 4 : 12 - i);
            chk("t1_out_valid", 32'(out_valid), (i >= 4) ? 32'd1 : 32'd0);
            chk("t1_occ", 32'(occupancy), 32'(occ_e));
            if (i == 4) begin
`ifdef PIPE_PERF_CNT_EN
                perf_bubble_e = 32'd4;
`else
                perf_bubble_e = 32'd0;
`endif
                chk("t1_perf_bubble", perf_bubble, perf_bubble_e);
            end
        end
        drain(2);

        // 2: fill with the consumer blocked, hold, then release.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 4'b0000);
            chk("t2_fill_in_ready", 32'(in_ready), 32'd1);
            chk("t2_fill_occ", 32'(occupancy), 32'(i));
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA4, 1'b0, 1'b0, 4'b0000);
            chk("t2_hold_in_ready", 32'(in_ready), 32'd0);
            chk("t2_hold_out_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_out_data", out_data, 32'hA0);
            chk("t2_hold_occ", 32'(occupancy), 32'd4);
        end
        for (int j = 4; j < 8; j++) begin
            drive(1'b1, 32'hA0 + 32'(j), 1'b1, 1'b0, 4'b0000);
            chk("t2_rel_in_ready", 32'(in_ready), 32'd1);
            chk("t2_rel_out_valid", 32'(out_valid), 32'd1);
        end
        drain(6);

        // 3: an input gap leaves a bubble that collapses while the consumer is blocked.
        for (int i = 0; i < 6; i++) begin
            drive(t3_iv[i] != 0, 32'hC0 + 32'(i), 1'b0, 1'b0, 4'b0000);
            chk("t3_in_ready", 32'(in_ready), 32'(t3_rdy[i]));
            chk("t3_occ", 32'(occupancy), 32'(t3_occ[i]));
        end
        drain(6);

        // 4: three-cycle stall mid-stream.
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hE0 + 32'(i), 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hE5, 1'b1, 1'b1, 4'b0000);
            chk("t4_out_valid", 32'(out_valid), 32'd0);
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            chk("t4_occ", 32'(occupancy), 32'd4);
            chk("t4_out_data", out_data, 32'hE1);
        end
        drive(1'b1, 32'hE5, 1'b1, 1'b0, 4'b0000);
`ifdef PIPE_PERF_CNT_EN
        perf_stall_e = 32'd3;
`else
        perf_stall_e = 32'd0;
`endif
        chk("t4_perf_stall", perf_stall, perf_stall_e);
        chk("t4_resume_out_data", out_data, 32'hE1);
        drain(8);

        // 5: flush stages 0 and 1 while stage 1 advances into stage 2.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hF0 + 32'(i), 1'b1, 1'b0, 4'b0000);
        drive(1'b1, 32'hF4, 1'b1, 1'b0, 4'b0011);
        chk("t5_pre_occ", 32'(occupancy), 32'd4);
        drop_exp(32'hF3);
        drop_exp(32'hF4);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000);
        chk("t5_post_occ", 32'(occupancy), 32'd2);
        drain(4);

        // 5b: flush the output stage during a stall; the other stages hold.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'b1000);
        chk("t5b_stall_out_valid", 32'(out_valid), 32'd0);
        drop_exp(32'h60);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'b0000);
        chk("t5b_occ", 32'(occupancy), 32'd3);
`ifdef PIPE_PERF_CNT_EN
        perf_stall_e = 32'd4;
`else
        perf_stall_e = 32'd0;
`endif
        chk("t5b_perf_stall", perf_stall, perf_stall_e);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'b0000);
        chk("t5b_collapse_out_data", out_data, 32'h61);
        drain(5);

        // 6: asynchronous reset between edges mid-stream, then a clean restart.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h90 + 32'(i), 1'b1, 1'b0, 4'b0000);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_data", out_data, RST_D);
        chk("t6_occ", 32'(occupancy), 32'd0);
        chk("t6_perf_stall", perf_stall, 32'd0);
        chk("t6_perf_bubble", perf_bubble, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(1'b1, 32'h77, 1'b1, 1'b0, 4'b0000);
        chk("t6_restart_in_ready", 32'(in_ready), 32'd1);
        drain(6);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
